// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing and receive-monitor state encoding.
// Used by both the VGA timing generator and the receive-side monitor.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/vga_rx_monitor_if.sv
// Video bus into the receive monitor plus its recovered timing and checksum results.
// master drives syncs/RGB (source side); slave is the monitor.
interface vga_rx_monitor_if;

    logic        hsync_in;
    logic        vsync_in;
    logic [5:0]  rgb_in;
    logic        locked;
    logic        de_out;
    logic [9:0]  x_out;
    logic [9:0]  y_out;
    logic        frame_valid;
    logic [15:0] frame_sum;
    logic        sync_err;

    modport master (
        output hsync_in, vsync_in, rgb_in,
        input  locked, de_out, x_out, y_out, frame_valid, frame_sum, sync_err
    );

    modport slave (
        input  hsync_in, vsync_in, rgb_in,
        output locked, de_out, x_out, y_out, frame_valid, frame_sum, sync_err
    );

endinterface

// File: rtl/vga_frame_sum.sv
// Mod-256 Fletcher accumulator over active pixels; clr restarts a frame, drop spoils it.
// Result registered one cycle after the capture pixel; no backpressure.
module vga_frame_sum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        cap,
    input  logic        drop,
    input  logic [5:0]  pix,
    output logic        frame_valid,
    output logic [15:0] frame_sum
);

    logic [7:0] sum1, sum2, sum1_nxt, sum2_nxt;
    logic       clean, take;

    always_comb begin
        sum1_nxt = clr ? 8'd0 : sum1;
        sum2_nxt = clr ? 8'd0 : sum2;
        if (en) begin
            sum1_nxt = sum1_nxt + {2'b00, pix};
            sum2_nxt = sum2_nxt + sum1_nxt;
        end
        // a frame only reports if it started clean and nothing spoiled it up to the last pixel
        take = cap && clean && !drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum1        <= '0;
            sum2        <= '0;
            clean       <= 1'b0;
            frame_valid <= 1'b0;
            frame_sum   <= '0;
        end else begin
            sum1        <= sum1_nxt;
            sum2        <= sum2_nxt;
            frame_valid <= take;
            if (take)
                frame_sum <= {sum2_nxt, sum1_nxt};
            if (drop)
                clean <= 1'b0;
            else if (clr)
                clean <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_rx_monitor.sv
// Locks to the VGA raster from hsync/vsync, regenerates x/y/de, checksums clean frames (VGA_RX_ERRCNT_EN adds err_count).
// All outputs registered, 1 cycle after the input sample; no backpressure.
module vga_rx_monitor #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_pkg::H_FRONT,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BACK   = vga_pkg::H_BACK,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_pkg::V_FRONT,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BACK   = vga_pkg::V_BACK
) (
    input  logic            clk,
    input  logic            rst,
    vga_rx_monitor_if.slave vid
`ifdef VGA_RX_ERRCNT_EN
    ,
    output logic [7:0]      err_count
`endif
);
    import vga_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]  HC_LOAD = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0]  HC_MAX  = 10'(H_TOT - 1);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]  VC_LOAD = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]  VC_MAX  = 10'(V_TOT - 1);
    localparam logic [10:0] HP_PER  = 11'(H_TOT);
    localparam logic [10:0] HP_SAT  = 11'(2 * H_TOT);
    localparam logic [10:0] VL_TOT  = 11'(V_TOT);

    rx_state_t   state;
    logic [9:0]  hc, vc, hc_nxt, vc_nxt;
    logic [10:0] hp, hp_nxt, vlines, vlines_nxt, vlines_meas;
    logic        hs_q, vs_q, primed, hp_valid, h_bad;
    logic        h_fall, v_fall, hc_wrap, de_nxt, h_mis, v_mis, hp_sat, err;
    logic        sum_clr, sum_cap;

    always_comb begin
        h_fall  = primed && hs_q && !vid.hsync_in;
        v_fall  = primed && vs_q && !vid.vsync_in;
        // an hsync fall reloads hc even when it lands on the wrap column
        hc_wrap = (hc == HC_MAX) && !h_fall;
        hc_nxt  = h_fall ? HC_LOAD : (hc_wrap ? 10'd0 : hc + 10'd1);
        vc_nxt  = vc;
        if (v_fall)
            vc_nxt = VC_LOAD;
        else if (hc_wrap)
            vc_nxt = (vc == VC_MAX) ? 10'd0 : vc + 10'd1;
        hp_nxt      = h_fall ? 11'd1 : ((hp == HP_SAT) ? HP_SAT : hp + 11'd1);
        vlines_meas = (vlines == 11'h7FF) ? vlines : vlines + {10'd0, hc_wrap};
        vlines_nxt  = v_fall ? 11'd0 : vlines_meas;
        de_nxt      = (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
        h_mis       = h_fall && hp_valid && (hp != HP_PER);
        v_mis       = v_fall && (vlines_meas != VL_TOT);
        hp_sat      = !h_fall && (hp == HP_SAT - 11'd1);
        err         = (state == LOCKED) && (h_mis || v_mis || hp_sat);
        sum_clr     = (state == LOCKED) && (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
        sum_cap     = (state == LOCKED) && (hc_nxt == H_ACT - 10'd1) && (vc_nxt == V_ACT - 10'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            primed     <= 1'b0;
            hc         <= '0;
            vc         <= '0;
            hp         <= '0;
            vlines     <= '0;
            hp_valid   <= 1'b0;
            h_bad      <= 1'b0;
            vid.locked   <= 1'b0;
            vid.sync_err <= 1'b0;
            vid.de_out   <= 1'b0;
            vid.x_out    <= '0;
            vid.y_out    <= '0;
        end else begin
            hs_q     <= vid.hsync_in;
            vs_q     <= vid.vsync_in;
            primed   <= 1'b1;
            hc       <= hc_nxt;
            vc       <= vc_nxt;
            hp       <= hp_nxt;
            vlines   <= vlines_nxt;
            if (h_fall)
                hp_valid <= 1'b1;
            if (h_mis)
                h_bad <= 1'b1;
            vid.sync_err <= err;
            vid.de_out   <= de_nxt;
            vid.x_out    <= de_nxt ? hc_nxt : 10'd0;
            vid.y_out    <= de_nxt ? vc_nxt : 10'd0;
            case (state)
                SEARCH: if (v_fall) begin
                    state <= ACQUIRE;
                    h_bad <= 1'b0;
                end
                ACQUIRE: if (v_fall) begin
                    if (!v_mis && !h_bad && !h_mis) begin
                        state      <= LOCKED;
                        vid.locked <= 1'b1;
                    end
                    h_bad <= 1'b0;
                end
                LOCKED: if (err) begin
                    state      <= SEARCH;
                    vid.locked <= 1'b0;
                    hp_valid   <= 1'b0;
                end
                default: begin
                    state      <= SEARCH;
                    vid.locked <= 1'b0;
                end
            endcase
        end
    end

    vga_frame_sum u_sum (
        .clk         (clk),
        .rst         (rst),
        .clr         (sum_clr),
        .en          (de_nxt),
        .cap         (sum_cap),
        .drop        (err),
        .pix         (vid.rgb_in),
        .frame_valid (vid.frame_valid),
        .frame_sum   (vid.frame_sum)
    );

`ifdef VGA_RX_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (vid.sync_err && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the VGA output path: consumes hsync/vsync and the 6-bit RGB bus, and recovers pixel timing.
- Locks to the 640x480@60 raster, regenerates x/y/de, and produces a per-frame checksum of active pixels.
- Sits on the loopback/self-test path so pattern and emblem output can be checked in simulation and on silicon.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BACK, 33, vertical back porch

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- hsync_in  in  1  active-low horizontal sync
- vsync_in  in  1  active-low vertical sync
- rgb_in  in  6  {R1,G1,B1,R0,G0,B0}, sampled with syncs
- locked  out  1  raster lock achieved
- de_out  out  1  recovered active-video flag
- x_out  out  10  recovered column
- y_out  out  10  recovered row
- frame_valid  out  1  one-cycle pulse; frame_sum valid
- frame_sum  out  16  {sum2,sum1} checksum of last clean frame
- sync_err  out  1  one-cycle pulse on timing violation while locked

Behaviour:
- All outputs are registered, with 1-cycle latency from the input sample. Reset clears all outputs to 0 and the state to SEARCH.
- Derived values: H_TOTAL=800, V_TOTAL=525.
- Edge detect: a falling edge is the current sample low with the previous sample high. The first sample after reset is never an edge.
- Horizontal counter hc:
  - On an hsync fall, hc loads H_ACTIVE+H_FRONT (656).
  - Otherwise hc increments, wrapping H_TOTAL-1 to 0.
- Vertical counter vc:
  - On a vsync fall, vc loads V_ACTIVE+V_FRONT (490).
  - Otherwise vc increments when hc wraps, wrapping V_TOTAL-1 to 0.
- hperiod: clocks between hsync falls, saturating at 2*H_TOTAL. At each fall, h_ok = (hperiod==H_TOTAL). The first fall after reset or SEARCH entry is not compared.
- vlines: hc wraps between vsync falls.
- de = (hc<H_ACTIVE)&&(vc<V_ACTIVE). x_out/y_out = hc/vc when de, else 0.
- FSM states:
  - SEARCH -> ACQUIRE on a vsync fall; clears the measurement.
  - ACQUIRE -> LOCKED on the next vsync fall if vlines==V_TOTAL and every hsync fall since was h_ok. Otherwise stay in ACQUIRE and restart the measurement.
  - LOCKED -> SEARCH on any of: an hsync fall with hperiod!=H_TOTAL; a vsync fall with vlines!=V_TOTAL; hperiod saturating (no hsync). Any of these pulses sync_err for 1 cycle.
  - locked = (state==LOCKED).
- Checksum (mod-256 Fletcher):
  - At hc==0, vc==0 in LOCKED: sum1=sum2=0 and clean=1.
  - Each active pixel: sum1+=rgb_in, then sum2+=new sum1 (8-bit wrap).
  - Leaving LOCKED clears clean.
- At the last active pixel (639,479), frame_sum <= {sum2', sum1'} and frame_valid pulses, but only if clean. frame_sum holds until the next valid frame.
- The first frame after lock is checksummed only if LOCKED at its (0,0).
- Simultaneous hsync fall and hc wrap: the load wins. A reset mid-frame discards the partial sum.

Optional Feature:
- Macro VGA_RX_ERRCNT_EN.
- When defined, adds output err_count[7:0]: counts sync_err pulses, saturates at 255, cleared by rst.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480 timing constants (also used by the VGA timing generator);
  - H_TOTAL/V_TOTAL;
  - the FSM state enum {SEARCH, ACQUIRE, LOCKED}.
- One natural sub-module: vga_frame_sum (Fletcher accumulator with clear/enable/capture).

Test Plan:
- Loopback from the timing generator after rst: locked rises 1 cycle after the second vsync fall. x_out/y_out match the generator's x/y delayed 1 cycle. sync_err stays 0.
- All-black frame while locked -> frame_valid pulses once per frame, at 1 cycle after pixel (639,479), with frame_sum=0x0000.
- Only pixel (639,479)=0x3F -> frame_sum=0x3F3F. Only pixel (0,0)=0x01 -> frame_sum=0x0001.
- While locked, shorten one line to 799 clocks -> sync_err pulses 1 cycle and locked=0. No frame_valid until relock; relock occurs at the second good vsync fall.
- Hold hsync high 1600+ clocks while locked -> sync_err pulses and the FSM enters SEARCH. With VGA_RX_ERRCNT_EN, err_count increments by 1.
- Assert rst mid-frame (y=200) -> all outputs 0 next cycle and locked=0. No stale frame_valid appears for the interrupted frame.
